alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: OPERAND_WIDTH, default 16, operand/result width; only 16 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_opcode  input  5  requester 0 ALU opcode (instruction bits 15:11).
REQ-007 req0_funct  input  2  requester 0 ALU funct (instruction bits 1:0).
REQ-008 req0_a, req0_b  input  16 each  requester 0 operands A and B.
REQ-009 req1_valid, req1_ready, req1_opcode, req1_funct, req1_a, req1_b: same directions, widths and meaning for requester 1.
REQ-010 rsp0_valid  output  1  result for requester 0 available.
REQ-011 rsp0_ready  input  1  requester 0 consumes result.
REQ-012 rsp0_data  output  16  result for requester 0.
REQ-013 rsp1_valid, rsp1_ready, rsp1_data: same for requester 1.
REQ-014 alu_opcode  output  5, alu_funct  output  2, alu_a  output  16, alu_b  output  16: operation driven to the shared combinational ALU.
REQ-015 alu_out  input  16  combinational result returned by the shared ALU.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-017 IDLE: if no req*_valid, stay IDLE; otherwise grant one requester, assert its req*_ready combinationally in the same cycle, and on the clock edge capture its opcode, funct, a, b and grant id into registers; next state EXEC.
REQ-018 req*_ready SHALL be 1 only in IDLE and only for the granted requester; never both high in one cycle.
REQ-019 Arbitration SHALL be round-robin: with only one valid, grant it; with both valid, grant the requester not granted last; the last-grant pointer updates only on a grant.
REQ-020 alu_opcode, alu_funct, alu_a and alu_b SHALL be driven directly from the captured registers in every state (no combinational path from req* inputs).
REQ-021 EXEC: lasts exactly one cycle; on its edge, capture alu_out into the result register; next state RESP.
REQ-022 RESP: assert rsp*_valid for the captured grant id only, with rsp*_data = result register; the other rsp*_valid SHALL be 0.
REQ-023 rsp*_data of the non-granted requester SHALL also equal the result register (value don't-care to consumers, but deterministic).
REQ-024 RESP: hold valid and data stable until rsp*_ready for the granted id is 1; on that edge return to IDLE; no new request is accepted in the RESP-exit cycle.
REQ-025 Minimum issue interval SHALL be 3 cycles (IDLE, EXEC, RESP with immediate ready); accept-to-rsp_valid latency SHALL be 2 cycles.
REQ-026 rsp*_ready while the matching rsp*_valid is 0 SHALL be ignored.
REQ-027 Request inputs changing or deasserting outside the accept cycle SHALL have no effect on an operation in flight.
REQ-028 Results SHALL be passed through unmodified; no width extension or truncation; the block does not interpret opcode/funct.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force state IDLE, all captured registers and result register to 0, last-grant pointer to requester 1 (so requester 0 wins the first contested grant).
REQ-030 During and after reset: req*_ready follow REQ-018 from IDLE, rsp*_valid = 0, rsp*_data = 0, alu_opcode = 0, alu_funct = 0, alu_a = alu_b = 0.
REQ-031 Reset asserted in EXEC or RESP SHALL abandon the in-flight operation; no response is ever issued for it.

Verification
REQ-032 Single request: req0 ADD opcode 5'b11011 funct 00, a=0x0003, b=0x0004, ALU model returns sum -> req0_ready high in accept cycle, rsp0_valid 2 cycles later with rsp0_data=0x0007, rsp1_valid stays 0.
REQ-033 Contention after reset: req0 and req1 both valid continuously, rsp*_ready tied 1 -> grants alternate 0,1,0,1; each issue 3 cycles apart.
REQ-034 Backpressure: rsp1_ready held 0 for 5 cycles in RESP -> rsp1_valid and rsp1_data stable for all 5 cycles, req0_ready stays 0 despite req0_valid=1; after rsp1_ready=1, req0 accepted 1 cycle later.
REQ-035 Input isolation: after accept, change req0_a from 0x00FF to 0xFFFF during EXEC -> alu_a remains 0x00FF, result unaffected.
REQ-036 Reset mid-operation: rst_n low during RESP with rsp0_valid=1 -> rsp0_valid drops immediately, outputs zero; after release, simultaneous requests grant requester 0 first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: a round-robin arbiter feeding
// a registered IDLE/EXEC/RESP sequencer. Only one operation is in flight at a time.
module alu_arbiter #(
  parameter int OPERAND_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [4:0]               req0_opcode,
  input  logic [1:0]               req0_funct,
  input  logic [OPERAND_WIDTH-1:0] req0_a,
  input  logic [OPERAND_WIDTH-1:0] req0_b,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [4:0]               req1_opcode,
  input  logic [1:0]               req1_funct,
  input  logic [OPERAND_WIDTH-1:0] req1_a,
  input  logic [OPERAND_WIDTH-1:0] req1_b,

  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [OPERAND_WIDTH-1:0] rsp0_data,

  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [OPERAND_WIDTH-1:0] rsp1_data,

  output logic [4:0]               alu_opcode,
  output logic [1:0]               alu_funct,
  output logic [OPERAND_WIDTH-1:0] alu_a,
  output logic [OPERAND_WIDTH-1:0] alu_b,
  input  logic [OPERAND_WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                     state, state_nxt;
  logic                       last_grant;
  logic                       grant_sel;
  logic                       grant_id;
  logic                       accept;
  logic                       rsp_done;
  logic [4:0]                 opcode_q;
  logic [1:0]                 funct_q;
  logic [OPERAND_WIDTH-1:0]   a_q;
  logic [OPERAND_WIDTH-1:0]   b_q;
  logic [OPERAND_WIDTH-1:0]   result_q;

  // Round-robin: a lone requester always wins; under contention the one not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = req1_valid;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_done = grant_id ? rsp1_ready : rsp0_ready;
        if (rsp_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign req0_ready = accept & ~grant_sel;
  assign req1_ready = accept &  grant_sel;

  assign rsp0_valid = (state == RESP) & ~grant_id;
  assign rsp1_valid = (state == RESP) &  grant_id;
  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;

  // The ALU sees only captured values, so requesters cannot disturb an operation in flight.
  assign alu_opcode = opcode_q;
  assign alu_funct  = funct_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Requester 1 counts as last served out of reset, so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_sel;
    end
  end

  // NOTE: these are plain registers, not a memory array, so each one is reset explicitly;
  // outputs derived from them are zero during and right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id <= 1'b0;
      opcode_q <= '0;
      funct_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (accept) begin
      grant_id <= grant_sel;
      opcode_q <= grant_sel ? req1_opcode : req0_opcode;
      funct_q  <= grant_sel ? req1_funct  : req0_funct;
      a_q      <= grant_sel ? req1_a      : req0_a;
      b_q      <= grant_sel ? req1_b      : req0_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (state == EXEC) begin
      result_q <= alu_out;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by random traffic, all scored against
// a transaction-level model (accept time, response time, round-robin owner).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_opcode, req1_opcode;
  logic [1:0]  req0_funct, req1_funct;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp0_data, rsp1_data;
  logic [4:0]  alu_opcode;
  logic [1:0]  alu_funct;
  logic [15:0] alu_a, alu_b, alu_out;

  always #5 clk = ~clk;

  alu_arbiter #(.OPERAND_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out)
  );

  // Stand-in for the shared ALU; the opcode nudges the result so it is observable.
  function automatic logic [15:0] alu_fn(logic [4:0] op, logic [1:0] fn, logic [15:0] a, logic [15:0] b);
    case (fn)
      2'd0:    alu_fn = a + b;
      2'd1:    alu_fn = a - b;
      2'd2:    alu_fn = a & b;
      default: alu_fn = a ^ b ^ {11'd0, op};
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_opcode, alu_funct, alu_a, alu_b);

  int errors = 0;
  int checks = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: one job at a time, response visible from accept+2 until consumed.
  int          cyc = 0;
  bit          m_busy;
  int          m_acc;
  bit          m_id;
  bit          m_last;
  logic [15:0] m_exp, m_res;
  logic [4:0]  m_op;
  logic [1:0]  m_fn;
  logic [15:0] m_a, m_b;
  int          gnt_q[$];
  int          gnt_cyc[$];

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_id = 0; m_acc = 0;
    m_op = '0; m_fn = '0; m_a = '0; m_b = '0; m_exp = '0; m_res = '0;
  endtask

  task automatic model_step();
    bit e_r0, e_r1, e_v0, e_v1, g;
    e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0; g = 0;
    if (req0_ready === 1'b1) begin gnt_q.push_back(0); gnt_cyc.push_back(cyc); end
    if (req1_ready === 1'b1) begin gnt_q.push_back(1); gnt_cyc.push_back(cyc); end
    check("alu_opcode", alu_opcode, m_op);
    check("alu_funct", alu_funct, m_fn);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        g = (req0_valid && req1_valid) ? !m_last : req1_valid;
        if (g) e_r1 = 1; else e_r0 = 1;
      end
    end else if (cyc >= m_acc + 2) begin
      m_res = m_exp;
      if (m_id) e_v1 = 1; else e_v0 = 1;
    end
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    check("rsp0_valid", rsp0_valid, e_v0);
    check("rsp1_valid", rsp1_valid, e_v1);
    check("rsp0_data", rsp0_data, m_res);
    check("rsp1_data", rsp1_data, m_res);
    if (e_r0 || e_r1) begin
      m_busy = 1; m_acc = cyc; m_id = g; m_last = g;
      m_op = g ? req1_opcode : req0_opcode;
      m_fn = g ? req1_funct  : req0_funct;
      m_a  = g ? req1_a      : req0_a;
      m_b  = g ? req1_b      : req0_b;
      m_exp = alu_fn(m_op, m_fn, m_a, m_b);
    end else if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
      m_busy = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req0_valid = 0; req1_valid = 0;
    rst_n = 0;
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp0_data", rsp0_data, 0);
    check("rst_rsp1_data", rsp1_data, 0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_alu_funct", alu_funct, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic idle_cycles(int n);
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < n; i++) begin tick(); adv(); end
  endtask

  logic [15:0] bp_exp;

  initial begin
    req0_opcode = '0; req0_funct = '0; req0_a = '0; req0_b = '0;
    req1_opcode = '0; req1_funct = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 0; rsp1_ready = 0;
    model_reset();
    apply_reset();
    idle_cycles(2);

    // Single ADD from requester 0: ready in accept cycle, response two cycles later.
    rsp0_ready = 1; rsp1_ready = 0;
    req0_valid = 1; req0_opcode = 5'b11011; req0_funct = 2'b00; req0_a = 16'h0003; req0_b = 16'h0004;
    tick();
    check("add_accept_ready", req0_ready, 1);
    adv();
    req0_valid = 0;
    tick(); adv();
    tick();
    check("add_rsp0_valid", rsp0_valid, 1);
    check("add_rsp0_data", rsp0_data, 16'h0007);
    check("add_rsp1_valid", rsp1_valid, 0);
    adv();
    idle_cycles(2);

    // Contention straight out of reset: grants alternate 0,1,0,1, three cycles apart.
    apply_reset();
    gnt_q.delete(); gnt_cyc.delete();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_opcode = 5'd3; req0_funct = 2'd1; req0_a = 16'h1234; req0_b = 16'h0034;
    req1_valid = 1; req1_opcode = 5'd9; req1_funct = 2'd3; req1_a = 16'hA5A5; req1_b = 16'h0F0F;
    for (int i = 0; i < 12; i++) begin tick(); adv(); end
    check("rr_grant_count", gnt_q.size(), 4);
    for (int i = 0; i < 4 && i < gnt_q.size(); i++) begin
      check("rr_grant_id", gnt_q[i], i % 2);
      if (i > 0) check("rr_issue_gap", gnt_cyc[i] - gnt_cyc[i-1], 3);
    end
    idle_cycles(2);

    // Backpressure on requester 1 while requester 0 waits.
    rsp1_ready = 0;
    req1_valid = 1; req1_opcode = 5'd17; req1_funct = 2'd2; req1_a = 16'hF0F0; req1_b = 16'h3C3C;
    bp_exp = alu_fn(5'd17, 2'd2, 16'hF0F0, 16'h3C3C);
    tick();
    check("bp_req1_ready", req1_ready, 1);
    adv();
    req1_valid = 0; req0_valid = 1; req0_funct = 2'd0; req0_a = 16'h0010; req0_b = 16'h0020;
    tick(); adv();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_rsp1_data", rsp1_data, bp_exp);
      check("bp_req0_ready", req0_ready, 0);
      adv();
    end
    rsp1_ready = 1;
    tick();
    check("bp_exit_req0_ready", req0_ready, 0);
    adv();
    tick();
    check("bp_req0_accept", req0_ready, 1);
    adv();
    idle_cycles(3);

    // Operand changes after accept must not reach the ALU.
    req0_valid = 1; req0_funct = 2'd0; req0_a = 16'h00FF; req0_b = 16'h0001;
    tick(); adv();
    req0_a = 16'hFFFF; req0_valid = 0;
    tick();
    check("iso_alu_a", alu_a, 16'h00FF);
    adv();
    tick();
    check("iso_rsp0_data", rsp0_data, 16'h0100);
    adv();
    idle_cycles(2);

    // Reset while a response is pending: it vanishes and requester 0 wins afterwards.
    rsp0_ready = 0;
    req0_valid = 1; req0_funct = 2'd1; req0_a = 16'h5000; req0_b = 16'h1000;
    tick(); adv();
    req0_valid = 0;
    tick(); adv();
    tick();
    check("mid_rsp0_valid_before", rsp0_valid, 1);
    adv();
    apply_reset();
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    tick();
    check("post_rst_req0_ready", req0_ready, 1);
    check("post_rst_req1_ready", req1_ready, 0);
    adv();
    idle_cycles(3);

    // Random traffic, inputs rerolled every cycle.
    for (int i = 0; i < 400; i++) begin
      req0_valid  = ($urandom_range(0, 99) < 60);
      req1_valid  = ($urandom_range(0, 99) < 60);
      req0_opcode = 5'($urandom); req0_funct = 2'($urandom);
      req0_a      = 16'($urandom); req0_b = 16'($urandom);
      req1_opcode = 5'($urandom); req1_funct = 2'($urandom);
      req1_a      = 16'($urandom); req1_b = 16'($urandom);
      rsp0_ready  = ($urandom_range(0, 99) < 70);
      rsp1_ready  = ($urandom_range(0, 99) < 70);
      tick(); adv();
    end
    idle_cycles(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
